// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Tracks the destination of the instructions in EX, MEM and WB, selects
// operand forwarding, inserts load-use bubbles, freezes the pipe while a
// load waits on data memory and squashes IF/ID on a taken branch.
// Stall and flush decisions are combinational so they act in the same
// cycle as the hazard; the slots, state and counters are registered.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   RUN        | normal flow, slots advance every cycle
//   LOAD_STALL | previous cycle inserted a load-use bubble into EX
//   MEM_WAIT   | load in MEM waiting for mem_ready_i, whole pipe frozen

module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_we_i,
  input  logic             id_is_load_i,
  input  logic [31:0]      ex_result_i,
  input  logic [31:0]      mem_result_i,
  input  logic [31:0]      wb_data_i,
  input  logic             mem_ready_i,
  input  logic             branch_taken_i,
  output logic             is_fwd_a_o,
  output logic             is_fwd_b_o,
  output logic [31:0]      dat_fwd_a_o,
  output logic [31:0]      dat_fwd_b_o,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_all_o,
  output logic             flush_id_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } slot_t;

  state_t            state;
  slot_t             ex_slot;
  slot_t             mem_slot;
  slot_t             wb_slot;
  slot_t             id_slot;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic              mem_wait;
  logic              load_use;
  logic              do_flush;
  logic              do_ld_stall;
  logic [32:0]       fwd_a;
  logic [32:0]       fwd_b;

  // Pick the youngest producer of src; a load still in EX has no data yet,
  // so it never forwards (the load-use bubble covers it).
  function automatic logic [32:0] fwd_pick(
    input logic [4:0]  src,
    input slot_t       ex_s,
    input slot_t       mem_s,
    input slot_t       wb_s,
    input logic [31:0] ex_d,
    input logic [31:0] mem_d,
    input logic [31:0] wb_d
  );
    logic [32:0] res;
    res = '0;
    if (src != 5'd0) begin
      if (ex_s.valid && ex_s.we && !ex_s.is_load && (ex_s.rd == src)) begin
        res = {1'b1, ex_d};
      end else if (mem_s.valid && mem_s.we && (mem_s.rd == src)) begin
        res = {1'b1, mem_d};
      end else if (wb_s.valid && wb_s.we && (wb_s.rd == src)) begin
        res = {1'b1, wb_d};
      end
    end
    return res;
  endfunction

  // Hazard detection and priority: memory wait, then branch, then load-use.
  always_comb begin
    if (state == MEM_WAIT) begin
      mem_wait = !mem_ready_i;
    end else begin
      mem_wait = mem_slot.valid && mem_slot.is_load && !mem_ready_i;
    end
    load_use = id_valid_i && ex_slot.valid && ex_slot.is_load &&
               (ex_slot.rd != 5'd0) &&
               ((ex_slot.rd == id_rs1_i) || (ex_slot.rd == id_rs2_i));
    do_flush    = !mem_wait && branch_taken_i;
    do_ld_stall = !mem_wait && !branch_taken_i && load_use;
    id_slot     = id_valid_i ? {1'b1, id_rd_i, id_we_i, id_is_load_i} : '0;
  end

  // Operand forwarding from the current slots.
  always_comb begin
    fwd_a = fwd_pick(id_rs1_i, ex_slot, mem_slot, wb_slot,
                     ex_result_i, mem_result_i, wb_data_i);
    fwd_b = fwd_pick(id_rs2_i, ex_slot, mem_slot, wb_slot,
                     ex_result_i, mem_result_i, wb_data_i);
  end

  // Control outputs, held quiet while reset is asserted.
  always_comb begin
    is_fwd_a_o  = rst_i && fwd_a[32];
    is_fwd_b_o  = rst_i && fwd_b[32];
    dat_fwd_a_o = rst_i ? fwd_a[31:0] : 32'd0;
    dat_fwd_b_o = rst_i ? fwd_b[31:0] : 32'd0;
    stall_if_o  = rst_i && do_ld_stall;
    stall_id_o  = rst_i && do_ld_stall;
    stall_all_o = rst_i && mem_wait;
    flush_id_o  = rst_i && do_flush;
    stall_cnt_o = stall_cnt;
    flush_cnt_o = flush_cnt;
  end

  // State and tracking slots: frozen during a memory wait, bubble on flush/stall.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= RUN;
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (mem_wait) begin
      state <= MEM_WAIT;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (do_flush || do_ld_stall) begin
        ex_slot <= '0;
      end else begin
        ex_slot <= id_slot;
      end
      state <= do_ld_stall ? LOAD_STALL : RUN;
    end
  end

  // Saturating stall and flush performance counters.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((mem_wait || do_ld_stall) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (do_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, a counter saturation
// sequence on a narrow-counter instance, then random traffic against a
// behavioural model of the pipeline's hazard rules.

module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [4:0]  rs1, rs2, rd;
  logic        we, ld;
  logic [31:0] exr, memr, wbd;
  logic        rdy, br;

  logic        fa, fb, sif, sid, sall, fl;
  logic [31:0] da, db;
  logic [15:0] scnt, fcnt;

  logic        fa4, fb4, sif4, sid4, sall4, fl4;
  logic [31:0] da4, db4;
  logic [3:0]  scnt4, fcnt4;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rd_i(rd), .id_we_i(we), .id_is_load_i(ld), .ex_result_i(exr),
    .mem_result_i(memr), .wb_data_i(wbd), .mem_ready_i(rdy), .branch_taken_i(br),
    .is_fwd_a_o(fa), .is_fwd_b_o(fb), .dat_fwd_a_o(da), .dat_fwd_b_o(db),
    .stall_if_o(sif), .stall_id_o(sid), .stall_all_o(sall), .flush_id_o(fl),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rd_i(rd), .id_we_i(we), .id_is_load_i(ld), .ex_result_i(exr),
    .mem_result_i(memr), .wb_data_i(wbd), .mem_ready_i(rdy), .branch_taken_i(br),
    .is_fwd_a_o(fa4), .is_fwd_b_o(fb4), .dat_fwd_a_o(da4), .dat_fwd_b_o(db4),
    .stall_if_o(sif4), .stall_id_o(sid4), .stall_all_o(sall4), .flush_id_o(fl4),
    .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = EX, 1 = MEM, 2 = WB.
  logic       m_v [3];
  logic [4:0] m_rd[3];
  logic       m_we[3];
  logic       m_ld[3];
  int         m_scnt, m_fcnt, m_scnt4, m_fcnt4;

  typedef struct {
    logic fa, fb, st, sa, fl;
    logic [31:0] da, db;
  } exp_t;

  function automatic void m_fwd(input logic [4:0] src, output logic hit, output logic [31:0] dat);
    logic [31:0] vals[3];
    vals[0] = exr; vals[1] = memr; vals[2] = wbd;
    hit = 1'b0;
    dat = 32'd0;
    if (src != 5'd0) begin
      for (int i = 0; i < 3; i++) begin
        if (!hit && m_v[i] && m_we[i] && m_rd[i] == src && !(i == 0 && m_ld[i])) begin
          hit = 1'b1;
          dat = vals[i];
        end
      end
    end
  endfunction

  function automatic logic m_memwait();
    return m_v[1] && m_ld[1] && !rdy;
  endfunction

  function automatic logic m_loaduse();
    return vld && m_v[0] && m_ld[0] && m_rd[0] != 5'd0 && (m_rd[0] == rs1 || m_rd[0] == rs2);
  endfunction

  function automatic exp_t m_eval();
    exp_t e;
    logic mw;
    mw = m_memwait();
    m_fwd(rs1, e.fa, e.da);
    m_fwd(rs2, e.fb, e.db);
    e.sa = mw;
    e.fl = !mw && br;
    e.st = !mw && !br && m_loaduse();
    if (!rst) begin
      e.fa = 0; e.fb = 0; e.da = 0; e.db = 0; e.sa = 0; e.fl = 0; e.st = 0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = m_eval();
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_rd[i] = 0; m_we[i] = 0; m_ld[i] = 0;
      end
      m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;
    end else begin
      if (e.st || e.sa) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt4 < 15) m_scnt4++;
      end
      if (e.fl) begin
        if (m_fcnt < 65535) m_fcnt++;
        if (m_fcnt4 < 15) m_fcnt4++;
      end
      if (!e.sa) begin
        for (int i = 2; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1];
        end
        if (e.fl || e.st || !vld) begin
          m_v[0] = 0; m_rd[0] = 0; m_we[0] = 0; m_ld[0] = 0;
        end else begin
          m_v[0] = 1; m_rd[0] = rd; m_we[0] = we; m_ld[0] = ld;
        end
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        r, v;
    logic [4:0]  s1, s2, d;
    logic        w, l, rdy_i, b;
    logic        fa, fb, st, sa, fl;
    logic [31:0] da, db;
    int          sc, fc;
  } vec_t;

  function automatic vec_t row(input string nm, input logic r, input logic v,
                               input int s1, input int s2, input int d,
                               input logic w, input logic l, input logic rdy_i, input logic b,
                               input logic fa_e, input int da_e, input logic fb_e, input int db_e,
                               input logic st_e, input logic sa_e, input logic fl_e,
                               input int sc_e, input int fc_e);
    vec_t t;
    t.name = nm; t.r = r; t.v = v;
    t.s1 = 5'(s1); t.s2 = 5'(s2); t.d = 5'(d);
    t.w = w; t.l = l; t.rdy_i = rdy_i; t.b = b;
    t.fa = fa_e; t.da = 32'(da_e); t.fb = fb_e; t.db = 32'(db_e);
    t.st = st_e; t.sa = sa_e; t.fl = fl_e; t.sc = sc_e; t.fc = fc_e;
    return t;
  endfunction

  task automatic set_in(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic w, input logic l,
                        input logic rdy_i, input logic b);
    rst = r; vld = v; rs1 = s1; rs2 = s2; rd = d; we = w; ld = l; rdy = rdy_i; br = b;
  endtask

  vec_t tbl[$];

  initial begin
    exp_t e;

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    exr = 32'h10; memr = 32'h20; wbd = 32'h30;

    //                 name           r v s1 s2 d  w l rdy b  fa da    fb db    st sa fl sc fc
    tbl.push_back(row("rst",          0,0, 0, 0, 0,0,0,1,0, 0,0,    0,0,    0,0,0, 0,0));
    tbl.push_back(row("addi_x5",      1,1, 0, 0, 5,1,0,1,0, 0,0,    0,0,    0,0,0, 0,0));
    tbl.push_back(row("ex_fwd",       1,1, 5, 5, 6,1,0,1,0, 1,'h10, 1,'h10, 0,0,0, 0,0));
    tbl.push_back(row("lw_x7",        1,1, 1, 0, 7,1,1,1,0, 0,0,    0,0,    0,0,0, 0,0));
    tbl.push_back(row("load_use",     1,1, 7, 1, 8,1,0,1,0, 0,0,    0,0,    1,0,0, 0,0));
    tbl.push_back(row("mem_fwd",      1,1, 7, 1, 8,1,0,1,0, 1,'h20, 0,0,    0,0,0, 1,0));
    tbl.push_back(row("wr_x0",        1,1, 0, 0, 0,1,0,1,0, 0,0,    0,0,    0,0,0, 1,0));
    tbl.push_back(row("rd_x0",        1,1, 0, 8, 9,1,0,1,0, 0,0,    1,'h20, 0,0,0, 1,0));
    tbl.push_back(row("lw_x10",       1,1, 0, 0,10,1,1,1,0, 0,0,    0,0,    0,0,0, 1,0));
    tbl.push_back(row("br_prio",      1,1,10, 9,11,1,0,1,1, 0,0,    1,'h20, 0,0,1, 1,0));
    tbl.push_back(row("flush_cnt",    1,0, 0, 0, 0,0,0,1,0, 0,0,    0,0,    0,0,0, 1,1));
    tbl.push_back(row("rst_mid",      0,0, 0, 0, 0,0,0,1,0, 0,0,    0,0,    0,0,0, 1,1));
    tbl.push_back(row("lw_x3",        1,1, 0, 0, 3,1,1,1,0, 0,0,    0,0,    0,0,0, 0,0));
    tbl.push_back(row("ex_ld_nofwd",  1,0, 3, 3, 0,0,0,1,0, 0,0,    0,0,    0,0,0, 0,0));
    tbl.push_back(row("mw1",          1,1, 3, 0,12,1,0,0,0, 1,'h20, 0,0,    0,1,0, 0,0));
    tbl.push_back(row("mw2",          1,1, 3, 0,12,1,0,0,0, 1,'h20, 0,0,    0,1,0, 1,0));
    tbl.push_back(row("mw3",          1,1, 3, 0,12,1,0,0,0, 1,'h20, 0,0,    0,1,0, 2,0));
    tbl.push_back(row("mw_done",      1,1, 3, 0,12,1,0,1,0, 1,'h20, 0,0,    0,0,0, 3,0));
    tbl.push_back(row("wb_fwd",       1,1, 3,12, 0,0,0,1,0, 1,'h30, 1,'h10, 0,0,0, 3,0));
    tbl.push_back(row("lw_x4",        1,1, 0, 0, 4,1,1,1,0, 0,0,    0,0,    0,0,0, 3,0));
    tbl.push_back(row("lu_x4",        1,1, 4, 0, 5,1,0,1,0, 0,0,    0,0,    1,0,0, 3,0));
    tbl.push_back(row("mw_after_lu",  1,1, 4, 0, 5,1,0,0,0, 1,'h20, 0,0,    0,1,0, 4,0));
    tbl.push_back(row("rst_in_wait",  0,1, 4, 0, 5,1,0,0,0, 0,0,    0,0,    0,0,0, 5,0));
    tbl.push_back(row("post_rst",     1,1, 4, 4, 0,0,0,0,0, 0,0,    0,0,    0,0,0, 0,0));

    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      set_in(tbl[i].r, tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].d,
             tbl[i].w, tbl[i].l, tbl[i].rdy_i, tbl[i].b);
      #1;
      chk({tbl[i].name, ".is_fwd_a"},  32'(fa),   32'(tbl[i].fa));
      chk({tbl[i].name, ".dat_fwd_a"}, da,        tbl[i].da);
      chk({tbl[i].name, ".is_fwd_b"},  32'(fb),   32'(tbl[i].fb));
      chk({tbl[i].name, ".dat_fwd_b"}, db,        tbl[i].db);
      chk({tbl[i].name, ".stall_if"},  32'(sif),  32'(tbl[i].st));
      chk({tbl[i].name, ".stall_id"},  32'(sid),  32'(tbl[i].st));
      chk({tbl[i].name, ".stall_all"}, 32'(sall), 32'(tbl[i].sa));
      chk({tbl[i].name, ".flush_id"},  32'(fl),   32'(tbl[i].fl));
      chk({tbl[i].name, ".stall_cnt"}, 32'(scnt), 32'(tbl[i].sc));
      chk({tbl[i].name, ".flush_cnt"}, 32'(fcnt), 32'(tbl[i].fc));
    end

    // Counter saturation on the 4-bit instance: 20 memory-wait cycles.
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); set_in(1, 1, 0, 0, 2, 1, 1, 1, 0);
    @(negedge clk); set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (20) begin
      @(negedge clk); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("sat.stall_all", 32'(sall4), 32'd1);
    end
    @(negedge clk); set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("sat.stall_cnt4", 32'(scnt4), 32'hF);
    chk("sat.stall_cnt16", 32'(scnt), 32'd20);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); set_in(1, 1, 2, 2, 0, 0, 0, 0, 0);
    #1;
    chk("sat_rst.is_fwd_a",  32'(fa4),   32'd0);
    chk("sat_rst.dat_fwd_a", da4,        32'd0);
    chk("sat_rst.is_fwd_b",  32'(fb4),   32'd0);
    chk("sat_rst.dat_fwd_b", db4,        32'd0);
    chk("sat_rst.stall_if",  32'(sif4),  32'd0);
    chk("sat_rst.stall_id",  32'(sid4),  32'd0);
    chk("sat_rst.stall_all", 32'(sall4), 32'd0);
    chk("sat_rst.flush_id",  32'(fl4),   32'd0);
    chk("sat_rst.stall_cnt", 32'(scnt4), 32'd0);
    chk("sat_rst.flush_cnt", 32'(fcnt4), 32'd0);

    // Random traffic against the behavioural model.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 99) >= 3);
      vld  = ($urandom_range(0, 99) < 80);
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      we   = ($urandom_range(0, 99) < 75);
      ld   = ($urandom_range(0, 99) < 35);
      rdy  = ($urandom_range(0, 99) < 70);
      br   = ($urandom_range(0, 99) < 15);
      exr  = $urandom;
      memr = $urandom;
      wbd  = $urandom;
      #1;
      e = m_eval();
      chk("rnd.is_fwd_a",   32'(fa),    32'(e.fa));
      chk("rnd.dat_fwd_a",  da,         e.da);
      chk("rnd.is_fwd_b",   32'(fb),    32'(e.fb));
      chk("rnd.dat_fwd_b",  db,         e.db);
      chk("rnd.stall_if",   32'(sif),   32'(e.st));
      chk("rnd.stall_id",   32'(sid),   32'(e.st));
      chk("rnd.stall_all",  32'(sall),  32'(e.sa));
      chk("rnd.flush_id",   32'(fl),    32'(e.fl));
      chk("rnd.stall_cnt",  32'(scnt),  32'(m_scnt));
      chk("rnd.flush_cnt",  32'(fcnt),  32'(m_fcnt));
      chk("rnd.stall_cnt4", 32'(scnt4), 32'(m_scnt4));
      chk("rnd.flush_cnt4", 32'(fcnt4), 32'(m_fcnt4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
